// File: rtl/rca_seq_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rca_seq_pkg
// Description : Shared types and constants for the nibble-serial adder
//               (controller state encoding, slice width).
// Revision    : 1.0 - initial release
// ============================================================================
package rca_seq_pkg;

  // Width of the shared ripple-carry slice
  localparam int NIBBLE = 4;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rca_seq_adder_rca4_slice.sv
`default_nettype none
// ============================================================================
// Module      : rca4_slice
// Description : Combinational 4-bit ripple-carry adder made of full-adder
//               cells. Also exposes the carry into bit 3 so the caller can
//               form a signed-overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rca4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  // w_c[i] is the carry into bit i; w_c[4] is the slice carry-out
  logic [4:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co = w_c[4];
  assign c3 = w_c[3];

endmodule
`default_nettype wire

// File: rtl/rca_seq_adder.sv
`default_nettype none
// ============================================================================
// Module      : rca_seq_adder
// Description : WIDTH-bit adder that reuses a single 4-bit ripple-carry
//               slice, one nibble per clock, LSB first, with the inter-nibble
//               carry held in a register. valid/ready on both sides.
//               Optional macro RCA_SEQ_OVF_EN adds a signed-overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_seq_adder
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB_CNT = WIDTH / NIBBLE;
  localparam int IDX_W   = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;

  // Reject widths the nibble-serial datapath cannot cover exactly
  if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_bad_width
    $error("rca_seq_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;

  logic [NIBBLE-1:0]  w_a_nib;
  logic [NIBBLE-1:0]  w_b_nib;
  logic [NIBBLE-1:0]  w_s;
  logic               w_co;
  logic               w_c3;
  logic               w_last;

  assign w_last = (r_idx == IDX_W'(NIB_CNT - 1));

  // Select the current operand nibbles for the shared slice
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int n = 0; n < NIB_CNT; n++) begin
      if (r_idx == IDX_W'(n)) begin
        w_a_nib = r_a[n*NIBBLE +: NIBBLE];
        w_b_nib = r_b[n*NIBBLE +: NIBBLE];
      end
    end
  end

  rca4_slice u_slice (
    .a  (w_a_nib),
    .b  (w_b_nib),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co),
    .c3 (w_c3)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture and nibble-serial accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_carry <= c_in;
            r_idx   <= '0;
          end
        end
        RUN: begin
          for (int n = 0; n < NIB_CNT; n++) begin
            if (r_idx == IDX_W'(n)) begin
              r_sum[n*NIBBLE +: NIBBLE] <= w_s;
            end
          end
          r_carry <= w_co;
          // idx saturates on the final nibble instead of wrapping
          if (!w_last) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RCA_SEQ_OVF_EN
  logic r_ovf;

  // Signed overflow taken from the top nibble: carry into MSB vs carry out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_ovf <= w_c3 ^ w_co;
    end
  end

  assign ovf = r_ovf;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN) || (r_state == DONE);
  assign sum       = r_sum;
  assign c_out     = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_rca_seq_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_seq_adder
// Description : Self-checking bench for rca_seq_adder at WIDTH=16 and
//               WIDTH=4 with an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_seq_adder;

  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        out_ready;
  logic        sel4;

  logic        in_valid16, in_valid4;
  logic        in_ready16, in_ready4;
  logic        out_valid16, out_valid4;
  logic [15:0] sum16;
  logic [3:0]  sum4;
  logic        c_out16, c_out4;
  logic        busy16, busy4;
  logic        ovf16, ovf4;

  logic        obs_in_ready, obs_out_valid, obs_busy, obs_co, obs_ov;
  logic [15:0] obs_sum;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign in_valid16 = in_valid & ~sel4;
  assign in_valid4  = in_valid & sel4;

  rca_seq_adder #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .sum       (sum16),
    .c_out     (c_out16),
    .busy      (busy16)
`ifdef RCA_SEQ_OVF_EN
    ,
    .ovf       (ovf16)
`endif
  );

  rca_seq_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a[3:0]),
    .b         (b[3:0]),
    .c_in      (c_in),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .sum       (sum4),
    .c_out     (c_out4),
    .busy      (busy4)
`ifdef RCA_SEQ_OVF_EN
    ,
    .ovf       (ovf4)
`endif
  );

`ifndef RCA_SEQ_OVF_EN
  assign ovf16 = 1'b0;
  assign ovf4  = 1'b0;
`endif

  assign obs_in_ready  = sel4 ? in_ready4  : in_ready16;
  assign obs_out_valid = sel4 ? out_valid4 : out_valid16;
  assign obs_busy      = sel4 ? busy4      : busy16;
  assign obs_sum       = sel4 ? {12'h000, sum4} : sum16;
  assign obs_co        = sel4 ? c_out4     : c_out16;
  assign obs_ov        = sel4 ? ovf4       : ovf16;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width add, carry and signed overflow from operand signs
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input int w);
    exp_t        e;
    logic [15:0] m;
    logic [16:0] full;
    m      = (w == 16) ? 16'hFFFF : 16'h000F;
    full   = {1'b0, x & m} + {1'b0, y & m} + {16'h0000, ci};
    e.sum  = full[15:0] & m;
    e.co   = (w == 16) ? full[16] : full[4];
`ifdef RCA_SEQ_OVF_EN
    e.ov   = (x[w-1] == y[w-1]) && (e.sum[w-1] != x[w-1]);
`else
    e.ov   = 1'b0;
`endif
    return e;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_in_ready"},  {31'd0, obs_in_ready}, 32'd1);
    check_val({tag, "_out_valid"}, {31'd0, obs_out_valid}, 32'd0);
    check_val({tag, "_busy"},      {31'd0, obs_busy}, 32'd0);
  endtask

  // Issue one operation; optionally stall the consumer for 'hold' cycles
  task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                       input logic ci, input int hold);
    int   nib;
    int   lat;
    exp_t e;
    nib = sel4 ? 1 : 4;
    out_ready = (hold == 0);
    a = x; b = y; c_in = ci; in_valid = 1'b1;
    check_val("acc_in_ready", {31'd0, obs_in_ready}, 32'd1);
    sb.push_back(model(x, y, ci, sel4 ? 4 : 16));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~x; b = ~y; c_in = ~ci;
    lat = 0;
    while (!obs_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency", lat, nib);
    if (!obs_out_valid) begin
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check_val("sum",   {16'd0, obs_sum}, {16'd0, e.sum});
    check_val("c_out", {31'd0, obs_co},  {31'd0, e.co});
    check_val("ovf",   {31'd0, obs_ov},  {31'd0, e.ov});
    for (int h = 0; h < hold; h++) begin
      check_val("hold_sum",   {16'd0, obs_sum}, {16'd0, e.sum});
      check_val("hold_c_out", {31'd0, obs_co},  {31'd0, e.co});
      check_val("hold_ready", {31'd0, obs_in_ready}, 32'd0);
      check_val("hold_busy",  {31'd0, obs_busy}, 32'd1);
      check_val("hold_valid", {31'd0, obs_out_valid}, 32'd1);
      in_valid = 1'b1;
      a = 16'hA5A5; b = 16'h5A5A;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    if (hold > 0) begin
      check_val("hold_end_sum", {16'd0, obs_sum}, {16'd0, e.sum});
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_idle_outputs("post_hs");
  endtask

  initial begin
    exp_t e;
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0;
    out_ready = 1'b1; sel4 = 1'b0;
    #1;
    check_idle_outputs("rst");
    check_val("rst_sum",   {16'd0, obs_sum}, 32'd0);
    check_val("rst_c_out", {31'd0, obs_co},  32'd0);
    check_val("rst_ovf",   {31'd0, obs_ov},  32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'h1234, 16'h4321, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 3);

    // Reset during the second RUN cycle discards the operation
    a = 16'h00FF; b = 16'h0001; c_in = 1'b0; in_valid = 1'b1;
    sb.push_back(model(16'h00FF, 16'h0001, 1'b0, 16));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_val("mid_busy", {31'd0, obs_busy}, 32'd1);
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    check_idle_outputs("mid_rst");
    check_val("mid_rst_sum",   {16'd0, obs_sum}, 32'd0);
    check_val("mid_rst_c_out", {31'd0, obs_co},  32'd0);
    check_val("mid_rst_ovf",   {31'd0, obs_ov},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h0002, 16'h0003, 1'b0, 0);

    for (int i = 0; i < 4; i++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), i % 2);
    end

    sel4 = 1'b1;
    #1;
    do_op(16'h0009, 16'h0008, 1'b0, 0);
    do_op(16'h0007, 16'h0001, 1'b0, 1);
    do_op(16'h000F, 16'h000F, 1'b1, 0);

    check_val("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rca_seq_adder.md
# rca_seq_adder

Multi-cycle WIDTH-bit adder controller that time-shares one 4-bit ripple-carry slice across all nibbles of the operands. It processes one nibble per clock, LSB first, and carries between nibbles in a register. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency (WIDTH/4 cycles) for the area of a single 4-bit adder.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- c_in  input  1  carry-in, sampled on accept.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, a+b+c_in mod 2^WIDTH.
- c_out  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.
- ovf  output  1  signed overflow; port exists only with RCA_SEQ_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at a clock edge:
  - latch a, b into operand registers;
  - load c_in into the carry register;
  - clear the nibble index to 0;
  - clear the sum register;
  - go to RUN.
- RUN: each edge, the slice adds nibble[idx] of A and B plus the carry register.
  - Write the 4-bit result into sum[4*idx+3:4*idx].
  - Write the slice carry-out into the carry register.
  - Increment idx.
  - When idx == WIDTH/4-1, go to DONE instead of incrementing.
- DONE: out_valid=1.
  - sum and c_out (= carry register) are held stable.
  - On out_valid&&out_ready, go to IDLE.
- in_valid is ignored outside IDLE and the operands are not resampled.
- idx counter width is $clog2(WIDTH/4), minimum 1 bit.
- No wrap-around: idx never exceeds WIDTH/4-1.
- Reset at any time, including mid-RUN or in DONE, is asynchronous:
  - the in-flight operation is discarded;
  - the FSM goes to IDLE;
  - all registers clear.

## Timing
- Reset values:
  - in_ready=1;
  - out_valid=0, busy=0;
  - sum=0, c_out=0;
  - ovf=0 when present;
  - state=IDLE, idx=0, carry=0.
- Accept at edge k. Nibble i is written at edge k+1+i. The FSM enters DONE at edge k+WIDTH/4. out_valid is high from that edge on.
- Latency from accept to out_valid is WIDTH/4 cycles.
- If out_ready is already high when out_valid rises, the handshake completes at the next edge. in_ready is high in the following cycle.
- Minimum initiation interval is WIDTH/4+2 cycles.
- in_ready, out_valid and busy are decoded from registered state only. There is no combinational path from inputs to outputs.
- With WIDTH=4 the block spends exactly one cycle in RUN.

## Configuration
- RCA_SEQ_OVF_EN defined:
  - port ovf exists;
  - a register captures (slice carry into bit 3) XOR (slice carry-out) on the final RUN nibble;
  - ovf is valid and held with out_valid in DONE;
  - ovf clears on reset and on accept.
- Not defined: port ovf and its register are absent. All other behaviour is identical.

## Structure
- Package rca_seq_pkg:
  - state enum type (IDLE, RUN, DONE);
  - localparam NIBBLE=4.
- Sub-module rca4_slice: combinational 4-bit ripple-carry adder built from full-adder cells.
  - Ports: a[3:0], b[3:0], ci, s[3:0], co, c3 (carry into bit 3).
  - Each bit i uses a[i]/b[i] with the carry from bit i-1.
  - Instantiated once in rca_seq_adder.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, c_in=0 → out_valid exactly 4 cycles after accept, sum=0x5555, c_out=0.
- a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, confirming the carry ripples through all four nibbles. With the macro, ovf=0.
- a=0x7FFF, b=0x0001, c_in=0 → sum=0x8000, c_out=0. With the macro, ovf=1.
- a=0xFFFF, b=0xFFFF, c_in=1 with out_ready held low 3 cycles in DONE:
  - sum=0xFFFF and c_out=1, stable throughout;
  - in_ready=0, busy=1;
  - in_valid pulses during DONE are ignored;
  - IDLE is reached one edge after out_ready rises.
- Deassert rst_n during the 2nd RUN cycle of a=0x00FF, b=0x0001:
  - all outputs return to reset values immediately;
  - after release, a=0x0002, b=0x0003 → sum=0x0005.
- WIDTH=4, a=0x9, b=0x8, c_in=0 → one RUN cycle, sum=0x1, c_out=1. With the macro, ovf=1.
